// File: rtl/pc_pkg.sv
// PC source encodings shared by the control unit and the PC/RAS unit.
package pc_pkg;
    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_JR  = 3'b010;
    localparam logic [2:0] PCSRC_J   = 3'b011;
    localparam logic [2:0] PCSRC_JAL = 3'b100;
    localparam logic [2:0] PCSRC_RET = 3'b101;
endpackage

// File: rtl/pc_ras_unit_if.sv
// Control/fetch-side bundle of the PC/RAS unit.
// Optional stats signals exist only when PC_RAS_STATS_EN is defined.
interface pc_ras_unit_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic              PCWre;
    logic [2:0]        PCSrc;
    logic [ADDR_W-1:0] immediate;
    logic [25:0]       addr;
    logic [ADDR_W-1:0] rs_val;
    logic [ADDR_W-1:0] curPC;
    logic [ADDR_W-1:0] PC4;
    logic [ADDR_W-1:0] nextPC;
    logic [CntW-1:0]   ras_count;
    logic [ADDR_W-1:0] ras_pred;
    logic              ras_miss;
    logic              ras_ovf;
`ifdef PC_RAS_STATS_EN
    logic [15:0]       ras_hits;
    logic [15:0]       ras_misses;
`endif

    modport master (
`ifdef PC_RAS_STATS_EN
        input  ras_hits, ras_misses,
`endif
        output PCWre, PCSrc, immediate, addr, rs_val,
        input  curPC, PC4, nextPC, ras_count, ras_pred, ras_miss, ras_ovf
    );

    modport slave (
`ifdef PC_RAS_STATS_EN
        output ras_hits, ras_misses,
`endif
        input  PCWre, PCSrc, immediate, addr, rs_val,
        output curPC, PC4, nextPC, ras_count, ras_pred, ras_miss, ras_ovf
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored. Entry storage is not reset.
module ras_stack #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                             CLK,
    input  logic                             Reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                push_data,
    output logic [ADDR_W-1:0]                top,
    output logic [$clog2(RAS_DEPTH):0]       count,
    output logic                             ovf
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0]   ptr_q, ptr_d, top_idx;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, empty;

    assign full    = (count_q == CntW'(RAS_DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = ptr_q - PtrW'(1);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push) begin
            ptr_d = ptr_q + PtrW'(1);
            if (full) ovf_d = 1'b1;
            else      count_d = count_q + CntW'(1);
        end else if (pop && !empty) begin
            ptr_d   = top_idx;
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[ptr_q] <= push_data;
    end

    assign top   = empty ? '0 : mem_q[top_idx];
    assign count = count_q;
    assign ovf   = ovf_q;
endmodule

// File: rtl/pc_ras_unit.sv
// Multi-cycle MIPS PC unit with return-address-stack prediction of jr $ra.
// Define PC_RAS_STATS_EN to add saturating hit/miss counters.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input logic            CLK,
    input logic            Reset,
    pc_ras_unit_if.slave   bus
);
    logic [ADDR_W-1:0] cur_pc_q, pc4, jump_tgt, next_pc, ras_top;
    logic              miss_q, miss_d;
    logic              is_jal, is_ret, push, pop, ras_empty;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;

    assign pc4    = cur_pc_q + ADDR_W'(4);
    assign is_jal = (bus.PCSrc == PCSRC_JAL);
    assign is_ret = (bus.PCSrc == PCSRC_RET);
    assign push   = bus.PCWre && is_jal;
    assign pop    = bus.PCWre && is_ret;

    // Region bits come from PC4; works for any ADDR_W >= 28.
    always_comb begin
        jump_tgt       = pc4;
        jump_tgt[27:0] = {bus.addr, 2'b00};
    end

    always_comb begin
        next_pc = pc4;
        case (bus.PCSrc)
            PCSRC_BR:              next_pc = pc4 + (bus.immediate << 2);
            PCSRC_JR, PCSRC_RET:   next_pc = bus.rs_val;
            PCSRC_J, PCSRC_JAL:    next_pc = jump_tgt;
            default:               next_pc = pc4;
        endcase
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc4),
        .top       (ras_top),
        .count     (ras_cnt),
        .ovf       (bus.ras_ovf)
    );

    assign ras_empty = (ras_cnt == '0);
    // An empty stack has no prediction, so any return counts as a miss.
    assign miss_d    = pop && (ras_empty || (ras_top != bus.rs_val));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cur_pc_q <= RESET_VECTOR;
            miss_q   <= 1'b0;
        end else begin
            if (bus.PCWre) cur_pc_q <= next_pc;
            miss_q <= miss_d;
        end
    end

`ifdef PC_RAS_STATS_EN
    logic [15:0] hits_q, misses_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (pop) begin
            if (miss_d) begin
                if (misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
            end else if (hits_q != 16'hFFFF) begin
                hits_q <= hits_q + 16'd1;
            end
        end
    end

    assign bus.ras_hits   = hits_q;
    assign bus.ras_misses = misses_q;
`endif

    assign bus.curPC     = cur_pc_q;
    assign bus.PC4       = pc4;
    assign bus.nextPC    = next_pc;
    assign bus.ras_count = ras_cnt;
    assign bus.ras_pred  = ras_top;
    assign bus.ras_miss  = miss_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed self-checking bench for pc_ras_unit (ADDR_W=32, RAS_DEPTH=4).
module tb_pc_ras_unit;
    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    pc_ras_unit_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

    pc_ras_unit #(
        .ADDR_W       (32),
        .RAS_DEPTH    (4),
        .RESET_VECTOR (32'h0)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [2:0]  src;
        logic [31:0] imm;
        logic [25:0] addr;
        logic [31:0] rs;
        logic [31:0] exp_next;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        logic [31:0] exp_pred;
        logic        exp_miss;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] src, input logic [31:0] imm,
                         input logic [25:0] a, input logic [31:0] rs);
        bus.PCWre     = we;
        bus.PCSrc     = src;
        bus.immediate = imm;
        bus.addr      = a;
        bus.rs_val    = rs;
    endtask

    // Apply inputs just after a negedge, commit on the next posedge, sample at the negedge.
    task automatic step(input logic we, input logic [2:0] src, input logic [31:0] imm,
                        input logic [25:0] a, input logic [31:0] rs);
        drive(we, src, imm, a, rs);
        @(negedge CLK);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd2, 32'h0, 26'h0, 32'h10,   32'h10,   32'h10,   3'd0, 32'h0,    1'b0};
        vecs[1]  = '{1'b0, 3'd1, 32'hFFFFFFFE, 26'h0, 32'h0, 32'h0C, 32'h10, 3'd0, 32'h0,  1'b0};
        vecs[2]  = '{1'b1, 3'd1, 32'hFFFFFFFE, 26'h0, 32'h0, 32'h0C, 32'h0C, 3'd0, 32'h0,  1'b0};
        vecs[3]  = '{1'b1, 3'd2, 32'h0, 26'h0, 32'h1000, 32'h1000, 32'h1000, 3'd0, 32'h0,    1'b0};
        vecs[4]  = '{1'b1, 3'd4, 32'h0, 26'h40, 32'h0,   32'h100,  32'h100,  3'd1, 32'h1004, 1'b0};
        vecs[5]  = '{1'b1, 3'd5, 32'h0, 26'h0, 32'h1004, 32'h1004, 32'h1004, 3'd0, 32'h0,    1'b0};
        vecs[6]  = '{1'b1, 3'd2, 32'h0, 26'h0, 32'h1000, 32'h1000, 32'h1000, 3'd0, 32'h0,    1'b0};
        vecs[7]  = '{1'b1, 3'd4, 32'h0, 26'h40, 32'h0,   32'h100,  32'h100,  3'd1, 32'h1004, 1'b0};
        vecs[8]  = '{1'b1, 3'd5, 32'h0, 26'h0, 32'h2000, 32'h2000, 32'h2000, 3'd0, 32'h0,    1'b1};
        vecs[9]  = '{1'b1, 3'd0, 32'h0, 26'h0, 32'h0,    32'h2004, 32'h2004, 3'd0, 32'h0,    1'b0};
        vecs[10] = '{1'b1, 3'd5, 32'h0, 26'h0, 32'h3000, 32'h3000, 32'h3000, 3'd0, 32'h0,    1'b1};
        vecs[11] = '{1'b1, 3'd6, 32'h0, 26'h0, 32'h7000, 32'h3004, 32'h3004, 3'd0, 32'h0,    1'b0};
        vecs[12] = '{1'b1, 3'd7, 32'h0, 26'h0, 32'h7000, 32'h3008, 32'h3008, 3'd0, 32'h0,    1'b0};
        vecs[13] = '{1'b0, 3'd5, 32'h0, 26'h0, 32'h5000, 32'h5000, 32'h3008, 3'd0, 32'h0,    1'b0};
        vecs[14] = '{1'b1, 3'd4, 32'h0, 26'h10, 32'h0,   32'h40,   32'h40,   3'd1, 32'h300C, 1'b0};
        vecs[15] = '{1'b0, 3'd5, 32'h0, 26'h0, 32'h0,    32'h0,    32'h40,   3'd1, 32'h300C, 1'b0};

        drive(1'b0, 3'd0, 32'h0, 26'h0, 32'h0);
        Reset = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset curPC", bus.curPC, 32'h0);
        check("reset count", 32'(bus.ras_count), 32'h0);
        check("reset pred", bus.ras_pred, 32'h0);
        check("reset miss", 32'(bus.ras_miss), 32'h0);
        check("reset ovf", 32'(bus.ras_ovf), 32'h0);
        check("reset PC4", bus.PC4, 32'h4);
        Reset = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].src, vecs[i].imm, vecs[i].addr, vecs[i].rs);
            #1;
            check($sformatf("v%0d nextPC", i), bus.nextPC, vecs[i].exp_next);
            @(negedge CLK);
            check($sformatf("v%0d curPC", i), bus.curPC, vecs[i].exp_pc);
            check($sformatf("v%0d count", i), 32'(bus.ras_count), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d pred", i), bus.ras_pred, vecs[i].exp_pred);
            check($sformatf("v%0d miss", i), 32'(bus.ras_miss), 32'(vecs[i].exp_miss));
        end
        check("no ovf yet", 32'(bus.ras_ovf), 32'h0);

        // Overflow: JALs at 0x0..0x40, each jumping to the next PC.
        step(1'b1, 3'd2, 32'h0, 26'h0, 32'h0);
        for (int k = 0; k < 5; k++) step(1'b1, 3'd4, 32'h0, 26'(4 * (k + 1)), 32'h0);
        check("ovf flag", 32'(bus.ras_ovf), 32'h1);
        check("ovf count", 32'(bus.ras_count), 32'h4);
        check("ovf curPC", bus.curPC, 32'h50);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_ra;
            exp_ra = 32'h44 - 32'(16 * k);
            check($sformatf("pop%0d pred", k), bus.ras_pred, exp_ra);
            step(1'b1, 3'd5, 32'h0, 26'h0, exp_ra);
            check($sformatf("pop%0d miss", k), 32'(bus.ras_miss), 32'h0);
            check($sformatf("pop%0d count", k), 32'(bus.ras_count), 32'(3 - k));
        end
        check("drained pred", bus.ras_pred, 32'h0);
        step(1'b1, 3'd5, 32'h0, 26'h0, 32'h14);
        check("empty pop miss", 32'(bus.ras_miss), 32'h1);
        check("empty pop count", 32'(bus.ras_count), 32'h0);
        check("ovf sticky", 32'(bus.ras_ovf), 32'h1);

        // Wrap and J region bits.
        step(1'b1, 3'd2, 32'h0, 26'h0, 32'hFFFFFFFC);
        check("wrap PC4", bus.PC4, 32'h0);
        step(1'b1, 3'd0, 32'h0, 26'h0, 32'h0);
        check("wrap curPC", bus.curPC, 32'h0);
        step(1'b1, 3'd2, 32'h0, 26'h0, 32'hF0000000);
        drive(1'b1, 3'd3, 32'h0, 26'h123, 32'h0);
        #1;
        check("J nextPC", bus.nextPC, 32'hF000048C);
        @(negedge CLK);
        check("J curPC", bus.curPC, 32'hF000048C);

        // Asynchronous reset mid-cycle with an update pending.
        step(1'b1, 3'd4, 32'h0, 26'h10, 32'h0);
        step(1'b1, 3'd2, 32'h0, 26'h0, 32'h40);
        check("pre-reset curPC", bus.curPC, 32'h40);
        check("pre-reset count", 32'(bus.ras_count), 32'h1);
        drive(1'b1, 3'd4, 32'h0, 26'h80, 32'h0);
        #2 Reset = 1'b0;
        #1;
        check("async curPC", bus.curPC, 32'h0);
        check("async count", 32'(bus.ras_count), 32'h0);
        check("async ovf", 32'(bus.ras_ovf), 32'h0);
        @(negedge CLK);
        check("held-reset curPC", bus.curPC, 32'h0);
        check("held-reset count", 32'(bus.ras_count), 32'h0);
        Reset = 1'b1;
        step(1'b1, 3'd0, 32'h0, 26'h0, 32'h0);
        check("post-reset curPC", bus.curPC, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the multi-cycle MIPS core. It is the successor to the single-width PC register, which supported only sequential, branch, jr and j targets.
- Adds jal/return modes.
- Adds a circular return-address stack (RAS) that predicts jr $ra targets and flags mispredictions.
- Sits between the control unit (PCSrc, PCWre) and instruction memory (curPC).

Parameters:
ADDR_W, 32, PC/address width in bits (>=28).
RAS_DEPTH, 4, number of RAS entries (power of two, >=2).
RESET_VECTOR, 0, curPC value after reset.

Ports:
CLK  input  1  clock; all state updates on posedge.
Reset  input  1  reset, asynchronous, active-low.
PCWre  input  1  PC write enable; gates all state updates.
PCSrc  input  3  target select (encodings below).
immediate  input  ADDR_W  sign-extended branch offset in words.
addr  input  26  j/jal target field.
rs_val  input  ADDR_W  register value for jr/return.
curPC  output  ADDR_W  current PC (registered).
PC4  output  ADDR_W  curPC+4 (combinational).
nextPC  output  ADDR_W  selected next PC (combinational).
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
ras_pred  output  ADDR_W  RAS top entry; 0 when empty.
ras_miss  output  1  one-cycle pulse after a return whose prediction was wrong.
ras_ovf  output  1  sticky: a push overwrote a valid entry.

Behaviour:
- Reset (async, Reset=0):
  - curPC=RESET_VECTOR; ras_count=0; RAS pointer=0; ras_miss=0; ras_ovf=0.
  - RAS entry contents are don't-care.
  - Reset asserted mid-operation overrides any pending update.
- PC4 = curPC+4, modulo 2^ADDR_W.
- nextPC is combinational from curPC and inputs, selected by PCSrc:
  - 000 SEQ: PC4.
  - 001 BR: PC4 + (immediate<<2), wrap-around.
  - 010 JR: rs_val.
  - 011 J: {PC4[ADDR_W-1:28], addr, 2'b00}.
  - 100 JAL: same target as J, and pushes PC4.
  - 101 RET: rs_val, and pops the RAS.
  - 110, 111: treated as SEQ; no RAS action.
- Posedge with PCWre=1:
  - curPC<=nextPC.
  - JAL push: RAS[ptr]<=PC4; ptr<=ptr+1 mod RAS_DEPTH.
    - If ras_count<RAS_DEPTH: ras_count increments.
    - If full: ras_count stays at RAS_DEPTH, the oldest entry is overwritten, and ras_ovf<=1.
  - RET pop:
    - If ras_count>0: ptr<=ptr-1; ras_count decrements; ras_miss<=(ras_pred!=rs_val).
    - If empty: ras_miss<=1; ptr and ras_count unchanged.
  - All other modes: ras_miss<=0.
- Posedge with PCWre=0:
  - curPC, RAS, ptr and ras_count hold.
  - ras_miss<=0.
- ras_pred = RAS[ptr-1] when ras_count>0, else 0. Combinational; valid in the same cycle RET is presented.
- ras_ovf clears only on reset.
- Latency: curPC reflects nextPC one posedge after PCWre=1; ras_miss is valid the cycle after the RET commit.

Optional Feature:
PC_RAS_STATS_EN
- Defined: adds 16-bit saturating outputs ras_hits and ras_misses.
  - A RET commit increments exactly one of them.
  - Both reset to 0 and saturate at 16'hFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pc_pkg: PCSrc localparams (PCSRC_SEQ, PCSRC_BR, PCSRC_JR, PCSRC_J, PCSRC_JAL, PCSRC_RET).
- Sub-module ras_stack (param RAS_DEPTH, ADDR_W) owns:
  - storage, pointer, count;
  - push/pop/overflow;
  - top-of-stack output.
- pc_ras_unit owns target mux, curPC register, and miss detection.

Test Plan:
- Reset mid-run with curPC=0x40 → curPC=0 immediately (async); ras_count=0; ras_ovf=0.
- BR at curPC=0x10, immediate=0xFFFFFFFE, PCWre=1 → curPC=0x0C; with PCWre=0 instead → curPC holds 0x10.
- JAL at curPC=0x1000, addr=0x40 → curPC=0x100; ras_count=1; ras_pred=0x1004. Then RET with rs_val=0x1004 → curPC=0x1004; ras_count=0; ras_miss=0.
- RET with rs_val=0x2000 while ras_pred=0x1004 → curPC=0x2000; ras_miss pulses for 1 cycle. RET with RAS empty → ras_miss=1; ras_count stays 0.
- 5 JALs at PCs 0x0,0x10,0x20,0x30,0x40 (DEPTH=4) → ras_ovf=1; ras_count=4; pops yield 0x44,0x34,0x24,0x14, then empty.
- J at curPC=0xF0000000 → nextPC upper bits from PC4 (0xF...). PC4 at curPC=0xFFFFFFFC → 0 (wrap).
